rom_load_sequencer: RTL and testbench
=====================================

Name: rom_load_sequencer

Overview:
- Sits between the HPS ioctl download stream and the game core's ROM write port.
- Steers each downloaded byte to one of four ROM regions (main CPU, sub CPU, sound CPU, graphics) as a one-hot write strobe with a region-local address.
- Holds the core in reset for the whole download plus a settle period.
- Reports load completion, size/ordering errors and a running 16-bit byte-sum checksum for the OSD/LED.

Parameters:
- R0_END, 24'h006000, exclusive end address of region 0 (main CPU ROM).
- R1_END, 24'h00C000, exclusive end address of region 1 (sub CPU ROM).
- R2_END, 24'h00E000, exclusive end address of region 2 (sound CPU ROM).
- R3_END, 24'h016000, exclusive end address of region 3 (graphics); also the required total image size.
- HOLD_CYC, 1024, cycles the core reset stays asserted after download ends (range 1..65535).

Ports:
- clk_sys  in  1  system clock; the single clock for all logic.
- RESET  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  high while the HPS download is in progress.
- ioctl_wr  in  1  single-cycle byte-valid strobe.
- ioctl_addr  in  25  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- rom_we  out  4  one-hot region write strobe, registered.
- rom_ad  out  17  region-local address (ioctl_addr minus region base).
- rom_dt  out  8  registered data.
- core_rst  out  1  reset to the game core.
- load_ok  out  1  last download completed with correct size and order.
- load_err  out  1  last download had a size, order or overflow error.
- csum  out  16  sum mod 2^16 of all accepted bytes of the last or current download.

Behaviour:
- Reset values:
  - rom_we=0, rom_ad=0, rom_dt=0.
  - core_rst=1, load_ok=0, load_err=0, csum=0.
  - State = IDLE; byte counter = 0; hold counter = 0.
- FSM states: IDLE, LOAD, CHECK, HOLD, RUN.
- IDLE: core_rst=1. Go to LOAD when ioctl_download=1.
- Entry to LOAD: clear the byte counter, csum, load_ok and load_err.
- LOAD, on each ioctl_wr=1:
  - Expected address = byte counter. A mismatch sets load_err (sticky until the next LOAD); the byte is still written.
  - addr < R0_END: rom_we=0001, rom_ad=addr.
  - addr < R1_END: rom_we=0010, rom_ad=addr-R0_END.
  - addr < R2_END: rom_we=0100, rom_ad=addr-R1_END.
  - addr < R3_END: rom_we=1000, rom_ad=addr-R2_END.
  - addr >= R3_END: rom_we=0000 (byte dropped), load_err=1.
- Write latency: rom_we/rom_ad/rom_dt are valid exactly 1 cycle after ioctl_wr and last exactly 1 cycle.
- Checksum and counter: accepted bytes (in range) add to csum mod 2^16. The byte counter increments on every ioctl_wr.
- ioctl_wr while not in LOAD is ignored: no strobe, no counter change.
- LOAD: when ioctl_download falls, go to CHECK.
  - A strobe coinciding with the falling edge is still accepted and counted.
- CHECK (1 cycle):
  - If byte counter != R3_END, set load_err.
  - load_ok = ~load_err (using the final value).
  - Then go to HOLD with hold counter = HOLD_CYC.
- HOLD: core_rst=1; hold counter decrements each cycle; go to RUN when it reaches 0.
  - If ioctl_download rises, go to LOAD (restart the download).
- RUN: core_rst=0. If ioctl_download rises, go to LOAD; core_rst rises on the next clock edge.
- core_rst is registered and high in every state except RUN. It must never glitch low during LOAD, CHECK or HOLD.
- A failed load (load_err=1) still proceeds to RUN; the error flag is informational.
- RESET mid-download aborts immediately to IDLE with reset values.
  - After RESET releases, if ioctl_download is still high, go to LOAD on the next edge; the counter restarts at 0.
  - The following bytes then mismatch unless the address is 0, which sets load_err.
- Address arithmetic is 25-bit unsigned; rom_ad is the low 17 bits of the difference.

Test Plan:
- Sequential download of bytes 0..0x15FFF with data = addr[7:0]:
  - rom_we=0001 for 0..0x5FFF, 0010 at 0x6000 with rom_ad=0.
  - rom_we=0100 at 0xC000, 1000 at 0xE000 with rom_ad=0.
  - load_ok=1, load_err=0, csum = expected mod-2^16 sum.
  - core_rst falls exactly HOLD_CYC+1 cycles after ioctl_download falls.
- Short image (ends after 0x15FFE): load_err=1, load_ok=0, core_rst still releases after HOLD.
- Extra byte at 0x16000: rom_we stays 0000 for that byte, csum unchanged by it, load_err=1.
- Skipped address (0x100 followed by 0x102): load_err=1; the 0x102 byte is still written with rom_we=0001, rom_ad=0x102.
- RESET asserted at byte 0x3000:
  - All outputs return to reset values within 0 cycles (async).
  - A subsequent clean full download gives load_ok=1.
- Download restarted while in RUN:
  - core_rst=1 one cycle after ioctl_download rises.
  - csum clears to 0 and load_ok clears to 0.

Source files
------------

// File: rtl/rom_load_sequencer_if.sv
// rom_load_sequencer_if
// Bundles the HPS ioctl download stream and the ROM write / status outputs
// of the ROM load sequencer.
//   slave  : the sequencer (consumes ioctl_*, drives rom_*, core_rst, status)
//   master : the download source / status consumer
// Signals:
//   ioctl_download  high while a download is in progress
//   ioctl_wr        single-cycle byte-valid strobe
//   ioctl_addr      byte address of ioctl_dout
//   ioctl_dout      download byte
//   rom_we          one-hot region write strobe
//   rom_ad          region-local byte address
//   rom_dt          write data
//   core_rst        reset to the game core
//   load_ok         last download completed with correct size and order
//   load_err        last download had a size, order or overflow error
//   csum            16-bit byte-sum of accepted bytes
interface rom_load_sequencer_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [3:0]  rom_we;
  logic [16:0] rom_ad;
  logic [7:0]  rom_dt;
  logic        core_rst;
  logic        load_ok;
  logic        load_err;
  logic [15:0] csum;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output rom_we, rom_ad, rom_dt, core_rst, load_ok, load_err, csum
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  rom_we, rom_ad, rom_dt, core_rst, load_ok, load_err, csum
  );
endinterface

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
// Steers downloaded ioctl bytes into four ROM regions (main, sub, sound,
// graphics) with a one-hot strobe and region-local address, keeps the game
// core in reset during the download plus HOLD_CYC settle cycles, and reports
// completion / error status and a running 16-bit byte-sum checksum.
// Ports:
//   clk_sys  system clock
//   RESET    asynchronous active-high reset
//   bus      rom_load_sequencer_if.slave (ioctl inputs, ROM/status outputs)
module rom_load_sequencer #(
  parameter logic [23:0] R0_END   = 24'h006000,
  parameter logic [23:0] R1_END   = 24'h00C000,
  parameter logic [23:0] R2_END   = 24'h00E000,
  parameter logic [23:0] R3_END   = 24'h016000,
  parameter int unsigned HOLD_CYC = 1024
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  rom_load_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  localparam logic [24:0] R0_END_W = {1'b0, R0_END};
  localparam logic [24:0] R1_END_W = {1'b0, R1_END};
  localparam logic [24:0] R2_END_W = {1'b0, R2_END};
  localparam logic [24:0] R3_END_W = {1'b0, R3_END};
  localparam logic [15:0] HOLD_W   = 16'(HOLD_CYC);

  state_t      state_q, state_d;
  logic [3:0]  rom_we_q, rom_we_d;
  logic [16:0] rom_ad_q, rom_ad_d;
  logic [7:0]  rom_dt_q, rom_dt_d;
  logic        core_rst_q, core_rst_d;
  logic        load_ok_q, load_ok_d;
  logic        load_err_q, load_err_d;
  logic [15:0] csum_q, csum_d;
  logic [24:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;

  logic [3:0]  reg_we_s;
  logic [24:0] base_s;
  logic        in_rng_s;
  logic        final_err_s;
  logic        load_entry_s;

  // Region decode of the incoming byte address: strobe, region base, in-range flag
  always_comb begin
    reg_we_s = 4'b0000;
    base_s   = 25'd0;
    in_rng_s = 1'b0;
    if (bus.ioctl_addr < R0_END_W) begin
      reg_we_s = 4'b0001;
      base_s   = 25'd0;
      in_rng_s = 1'b1;
    end else if (bus.ioctl_addr < R1_END_W) begin
      reg_we_s = 4'b0010;
      base_s   = R0_END_W;
      in_rng_s = 1'b1;
    end else if (bus.ioctl_addr < R2_END_W) begin
      reg_we_s = 4'b0100;
      base_s   = R1_END_W;
      in_rng_s = 1'b1;
    end else if (bus.ioctl_addr < R3_END_W) begin
      reg_we_s = 4'b1000;
      base_s   = R2_END_W;
      in_rng_s = 1'b1;
    end else begin
      reg_we_s = 4'b0000;
      base_s   = 25'd0;
      in_rng_s = 1'b0;
    end
  end

  // Final error verdict evaluated in CHECK: sticky errors or wrong image size
  always_comb begin
    final_err_s = load_err_q | (cnt_q != R3_END_W);
  end

  // State register
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.ioctl_download) state_d = LOAD;
        else                    state_d = IDLE;
      end
      LOAD: begin
        if (bus.ioctl_download) state_d = LOAD;
        else                    state_d = CHECK;
      end
      CHECK: begin
        state_d = HOLD;
      end
      HOLD: begin
        // hold_q of 1 means this cycle's decrement reaches zero
        if (bus.ioctl_download)    state_d = LOAD;
        else if (hold_q <= 16'd1)  state_d = RUN;
        else                       state_d = HOLD;
      end
      RUN: begin
        if (bus.ioctl_download) state_d = LOAD;
        else                    state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    load_entry_s = (state_q != LOAD) && (state_d == LOAD);
    rom_we_d     = 4'b0000;
    rom_ad_d     = rom_ad_q;
    rom_dt_d     = rom_dt_q;
    load_ok_d    = load_ok_q;
    load_err_d   = load_err_q;
    csum_d       = csum_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    // core_rst is registered from the next state so it drops only on RUN entry
    core_rst_d   = (state_d != RUN);
    if (load_entry_s) begin
      cnt_d      = 25'd0;
      csum_d     = 16'd0;
      load_ok_d  = 1'b0;
      load_err_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          // A strobe on the same cycle download falls is still processed here
          if (bus.ioctl_wr) begin
            cnt_d    = cnt_q + 25'd1;
            rom_dt_d = bus.ioctl_dout;
            if (bus.ioctl_addr != cnt_q) begin
              load_err_d = 1'b1;
            end else begin
              load_err_d = load_err_q;
            end
            if (in_rng_s) begin
              rom_we_d = reg_we_s;
              rom_ad_d = 17'(bus.ioctl_addr - base_s);
              csum_d   = csum_q + {8'h00, bus.ioctl_dout};
            end else begin
              load_err_d = 1'b1;
            end
          end else begin
            rom_we_d = 4'b0000;
          end
        end
        CHECK: begin
          load_err_d = final_err_s;
          load_ok_d  = ~final_err_s;
          hold_d     = HOLD_W;
        end
        HOLD: begin
          hold_d = hold_q - 16'd1;
        end
        default: begin
          hold_d = hold_q;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      rom_we_q   <= 4'b0000;
      rom_ad_q   <= 17'd0;
      rom_dt_q   <= 8'h00;
      core_rst_q <= 1'b1;
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
      csum_q     <= 16'd0;
      cnt_q      <= 25'd0;
      hold_q     <= 16'd0;
    end else begin
      rom_we_q   <= rom_we_d;
      rom_ad_q   <= rom_ad_d;
      rom_dt_q   <= rom_dt_d;
      core_rst_q <= core_rst_d;
      load_ok_q  <= load_ok_d;
      load_err_q <= load_err_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.rom_we   = rom_we_q;
  assign bus.rom_ad   = rom_ad_q;
  assign bus.rom_dt   = rom_dt_q;
  assign bus.core_rst = core_rst_q;
  assign bus.load_ok  = load_ok_q;
  assign bus.load_err = load_err_q;
  assign bus.csum     = csum_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Testbench for rom_load_sequencer with scaled-down region sizes so that many
// complete downloads fit in a short run. Expected values come from a
// behavioural model: region lookup from the list of end addresses, a running
// expected byte count, sticky error and byte-sum.
module tb_rom_load_sequencer;

  localparam int R0   = 32'h60;
  localparam int R1   = 32'hC0;
  localparam int R2   = 32'hE0;
  localparam int R3   = 32'h160;
  localparam int HOLD = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  // behavioural model state
  int        m_cnt;
  bit        m_err;
  bit [15:0] m_csum;
  int        ends [4];

  rom_load_sequencer_if bus ();

  rom_load_sequencer #(
    .R0_END   (24'(R0)),
    .R1_END   (24'(R1)),
    .R2_END   (24'(R2)),
    .R3_END   (24'(R3)),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk_sys (clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_cnt  = 0;
    m_err  = 1'b0;
    m_csum = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_dout = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.rom_we !== 4'b0000) begin n_bad++; $display("FAIL reset_rom_we got=%b exp=0000", bus.rom_we); end
    n_cmp++; if (bus.rom_ad !== 17'd0) begin n_bad++; $display("FAIL reset_rom_ad got=%h exp=0", bus.rom_ad); end
    n_cmp++; if (bus.rom_dt !== 8'h00) begin n_bad++; $display("FAIL reset_rom_dt got=%h exp=0", bus.rom_dt); end
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_bad++; $display("FAIL reset_core_rst got=%b exp=1", bus.core_rst); end
    n_cmp++; if (bus.load_ok !== 1'b0) begin n_bad++; $display("FAIL reset_load_ok got=%b exp=0", bus.load_ok); end
    n_cmp++; if (bus.load_err !== 1'b0) begin n_bad++; $display("FAIL reset_load_err got=%b exp=0", bus.load_err); end
    n_cmp++; if (bus.csum !== 16'd0) begin n_bad++; $display("FAIL reset_csum got=%h exp=0", bus.csum); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_bad++; $display("FAIL idle_core_rst got=%b exp=1", bus.core_rst); end
  endtask

  // Raise download; one edge later the sequencer is in LOAD with cleared status.
  task automatic begin_download();
    bus.ioctl_download = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_bad++; $display("FAIL start_core_rst got=%b exp=1", bus.core_rst); end
    n_cmp++; if (bus.csum !== 16'd0) begin n_bad++; $display("FAIL start_csum got=%h exp=0", bus.csum); end
    n_cmp++; if (bus.load_ok !== 1'b0) begin n_bad++; $display("FAIL start_load_ok got=%b exp=0", bus.load_ok); end
    n_cmp++; if (bus.load_err !== 1'b0) begin n_bad++; $display("FAIL start_load_err got=%b exp=0", bus.load_err); end
  endtask

  // Send one byte (optionally dropping download on the same edge) and check
  // the strobe produced one cycle later, then idle for gap cycles.
  task automatic send_byte(input int a, input bit [7:0] d, input int gap, input bit fall);
    int       reg_idx;
    int       base;
    bit [3:0] exp_we;
    bit [16:0] exp_ad;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = d;
    if (fall) bus.ioctl_download = 1'b0;
    @(posedge clk);
    #1;
    bus.ioctl_wr = 1'b0;
    reg_idx = 4;
    for (int i = 3; i >= 0; i--) if (a < ends[i]) reg_idx = i;
    base   = (reg_idx == 0 || reg_idx == 4) ? 0 : ends[reg_idx - 1];
    exp_we = (reg_idx == 4) ? 4'b0000 : 4'(1 << reg_idx);
    exp_ad = 17'(a - base);
    if (a != m_cnt) m_err = 1'b1;
    m_cnt++;
    if (reg_idx == 4) m_err = 1'b1;
    else m_csum = m_csum + 16'(d);
    n_cmp++; if (bus.rom_we !== exp_we) begin n_bad++; $display("FAIL byte_rom_we addr=%h got=%b exp=%b", a, bus.rom_we, exp_we); end
    if (reg_idx != 4) begin
      n_cmp++; if (bus.rom_ad !== exp_ad) begin n_bad++; $display("FAIL byte_rom_ad addr=%h got=%h exp=%h", a, bus.rom_ad, exp_ad); end
      n_cmp++; if (bus.rom_dt !== d) begin n_bad++; $display("FAIL byte_rom_dt addr=%h got=%h exp=%h", a, bus.rom_dt, d); end
    end
    n_cmp++; if (bus.csum !== m_csum) begin n_bad++; $display("FAIL byte_csum addr=%h got=%h exp=%h", a, bus.csum, m_csum); end
    n_cmp++; if (bus.load_err !== m_err) begin n_bad++; $display("FAIL byte_load_err addr=%h got=%b exp=%b", a, bus.load_err, m_err); end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (bus.rom_we !== 4'b0000) begin n_bad++; $display("FAIL gap_rom_we addr=%h got=%b exp=0000", a, bus.rom_we); end
    end
  endtask

  // End the download (unless already dropped with the last byte) and check
  // status plus the exact core_rst release cycle.
  task automatic finish_download(input bit fell);
    bit exp_err;
    if (!fell) begin
      bus.ioctl_download = 1'b0;
      @(posedge clk);
      #1;
    end
    exp_err = m_err || (m_cnt != R3);
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_bad++; $display("FAIL check_core_rst got=%b exp=1", bus.core_rst); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.load_err !== exp_err) begin n_bad++; $display("FAIL end_load_err got=%b exp=%b", bus.load_err, exp_err); end
    n_cmp++; if (bus.load_ok !== !exp_err) begin n_bad++; $display("FAIL end_load_ok got=%b exp=%b", bus.load_ok, !exp_err); end
    n_cmp++; if (bus.csum !== m_csum) begin n_bad++; $display("FAIL end_csum got=%h exp=%h", bus.csum, m_csum); end
    repeat (HOLD - 1) @(posedge clk);
    #1;
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_bad++; $display("FAIL hold_core_rst got=%b exp=1", bus.core_rst); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.core_rst !== 1'b0) begin n_bad++; $display("FAIL run_core_rst got=%b exp=0", bus.core_rst); end
    n_cmp++; if (bus.load_ok !== !exp_err) begin n_bad++; $display("FAIL run_load_ok got=%b exp=%b", bus.load_ok, !exp_err); end
  endtask

  task automatic test_sequential();
    begin_download();
    for (int a = 0; a < R3; a++) begin
      send_byte(a, 8'(a), (a == R3 - 1) ? 0 : int'($urandom_range(0, 2)), a == R3 - 1);
    end
    finish_download(1'b1);
  endtask

  task automatic test_short();
    begin_download();
    for (int a = 0; a < R3 - 1; a++) send_byte(a, 8'($urandom), int'($urandom_range(0, 1)), 1'b0);
    finish_download(1'b0);
  endtask

  task automatic test_extra();
    begin_download();
    for (int a = 0; a <= R3; a++) send_byte(a, 8'($urandom), int'($urandom_range(0, 1)), 1'b0);
    finish_download(1'b0);
  endtask

  task automatic test_skip();
    begin_download();
    for (int a = 0; a <= 32'h20; a++) send_byte(a, 8'($urandom), 0, 1'b0);
    for (int a = 32'h22; a < R3; a++) send_byte(a, 8'($urandom), int'($urandom_range(0, 1)), 1'b0);
    finish_download(1'b0);
  endtask

  task automatic test_reset_mid();
    begin_download();
    for (int a = 0; a <= 32'h30; a++) send_byte(a, 8'($urandom_range(1, 255)), 0, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.rom_ad !== 17'd0) begin n_bad++; $display("FAIL mid_reset_rom_ad got=%h exp=0", bus.rom_ad); end
    n_cmp++; if (bus.rom_dt !== 8'h00) begin n_bad++; $display("FAIL mid_reset_rom_dt got=%h exp=0", bus.rom_dt); end
    n_cmp++; if (bus.csum !== 16'd0) begin n_bad++; $display("FAIL mid_reset_csum got=%h exp=0", bus.csum); end
    n_cmp++; if (bus.core_rst !== 1'b1) begin n_bad++; $display("FAIL mid_reset_core_rst got=%b exp=1", bus.core_rst); end
    n_cmp++; if (bus.load_err !== 1'b0) begin n_bad++; $display("FAIL mid_reset_load_err got=%b exp=0", bus.load_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // download still high: next edge re-enters LOAD with the counter at 0
    @(posedge clk);
    #1;
    model_clear();
    for (int a = 32'h31; a < 32'h40; a++) send_byte(a, 8'($urandom), 0, 1'b0);
    finish_download(1'b0);
    // clean full download afterwards
    begin_download();
    for (int a = 0; a < R3; a++) send_byte(a, 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
    finish_download(1'b0);
  endtask

  task automatic test_restart_from_run();
    bit [15:0] prev_csum;
    prev_csum = m_csum;
    // stray strobe while running is ignored
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_dout = 8'hAA;
    @(posedge clk);
    #1;
    bus.ioctl_wr = 1'b0;
    n_cmp++; if (bus.rom_we !== 4'b0000) begin n_bad++; $display("FAIL run_stray_rom_we got=%b exp=0000", bus.rom_we); end
    n_cmp++; if (bus.csum !== prev_csum) begin n_bad++; $display("FAIL run_stray_csum got=%h exp=%h", bus.csum, prev_csum); end
    n_cmp++; if (bus.core_rst !== 1'b0) begin n_bad++; $display("FAIL run_core_rst_pre got=%b exp=0", bus.core_rst); end
    begin_download();
    for (int a = 0; a < R3; a++) send_byte(a, 8'($urandom), 0, 1'b0);
    finish_download(1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ends[0] = R0;
    ends[1] = R1;
    ends[2] = R2;
    ends[3] = R3;
    model_clear();
    test_reset();
    test_sequential();
    test_short();
    test_extra();
    test_skip();
    test_reset_mid();
    test_restart_from_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
